// File: rtl/adder_pkg.sv
// Shared definitions for the adder library: lane limit, the half-adder
// result type and the reference evaluation function.
package adder_pkg;

  localparam int HA_MAX_LANES = 64;

  typedef struct packed {
    logic cout;
    logic sum;
  } ha_res_t;

  function automatic ha_res_t ha_eval(input logic a, input logic b);
    ha_res_t r_res;
    r_res.cout = a & b;
    r_res.sum  = a ^ b;
    return r_res;
  endfunction

endpackage

// File: rtl/ha_cell.sv
// Structural single-bit half-adder cell: one XOR for the sum, one AND for
// the carry.
module ha_cell (
  output logic cout,
  output logic sum,
  input  logic a,
  input  logic b
);

  assign sum  = a ^ b;
  assign cout = a & b;

endmodule

// File: rtl/half_adder.sv
// Multi-lane half adder. Define HALF_ADDER_REG_OUT_EN for a registered
// output stage (1-cycle latency); otherwise the outputs are combinational.
module half_adder
  import adder_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [LANES-1:0] cout,
  output logic [LANES-1:0] sum,
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  input  logic             in_valid,
  output logic             out_valid
);

  logic [LANES-1:0] w_cout_c;
  logic [LANES-1:0] w_sum_c;

  if ((LANES < 1) || (LANES > HA_MAX_LANES)) begin : g_bad_lanes
    $error("half_adder: LANES=%0d outside 1..%0d", LANES, HA_MAX_LANES);
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    ha_cell u_cell (
      .cout (w_cout_c[gi]),
      .sum  (w_sum_c[gi]),
      .a    (a[gi]),
      .b    (b[gi])
    );
  end

`ifdef HALF_ADDER_REG_OUT_EN
  logic [LANES-1:0] r_cout;
  logic [LANES-1:0] r_sum;
  logic             r_out_valid;

  // Result registers load only on valid input; the valid flag follows every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cout      <= '0;
      r_sum       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (in_valid) begin
        r_cout <= w_cout_c;
        r_sum  <= w_sum_c;
      end else begin
        r_cout <= r_cout;
        r_sum  <= r_sum;
      end
      r_out_valid <= in_valid;
    end
  end

  assign cout      = r_cout;
  assign sum       = r_sum;
  assign out_valid = r_out_valid;
`else
  // Clock and reset stay on the interface but do not affect this build.
  logic w_unused;
  assign w_unused  = clk ^ rst_n;

  assign cout      = w_cout_c;
  assign sum       = w_sum_c;
  assign out_valid = in_valid;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder: a 1-lane and an 8-lane instance, checked
// in either the registered or the combinational build.
module tb_half_adder;
  import adder_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [0:0] a1, b1, cout1, sum1;
  logic       iv1, ov1;
  logic [7:0] a8, b8, cout8, sum8;
  logic       iv8, ov8;

  int checks;
  int failures;

  ha_res_t     q1[$];
  logic [15:0] q8[$];

  half_adder #(.LANES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cout(cout1), .sum(sum1),
    .a(a1), .b(b1), .in_valid(iv1), .out_valid(ov1)
  );

  half_adder #(.LANES(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .cout(cout8), .sum(sum8),
    .a(a8), .b(b8), .in_valid(iv8), .out_valid(ov8)
  );

  always #5 clk = ~clk;

  // Independent per-lane model: {cout, sum} is the 2-bit arithmetic sum.
  function automatic logic [15:0] exp8(input logic [7:0] av, input logic [7:0] bv);
    logic [7:0] c;
    logic [7:0] s;
    logic [1:0] t;
    for (int i = 0; i < 8; i++) begin
      t    = {1'b0, av[i]} + {1'b0, bv[i]};
      c[i] = t[1];
      s[i] = t[0];
    end
    return {c, s};
  endfunction

  task automatic drive(input logic a1v, input logic b1v, input logic v1,
                       input logic [7:0] a8v, input logic [7:0] b8v, input logic v8);
    @(negedge clk);
    a1  = a1v;
    b1  = b1v;
    iv1 = v1;
    a8  = a8v;
    b8  = b8v;
    iv8 = v8;
    if (v1) q1.push_back(ha_eval(a1v, b1v));
    if (v8) q8.push_back(exp8(a8v, b8v));
`ifdef HALF_ADDER_REG_OUT_EN
    @(posedge clk);
`endif
    #1;
  endtask

  task automatic test_pkg_model;
    ha_res_t r;
    logic [1:0] tt[4];
    tt[0] = 2'b00; tt[1] = 2'b01; tt[2] = 2'b01; tt[3] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      r = ha_eval(i[1], i[0]);
      checks++;
      if (r !== tt[i]) begin
        failures++;
        $display("FAIL pkg_ha_eval ab=%0d got=%b exp=%b", i, r, tt[i]);
      end
    end
  endtask

  task automatic test_reset;
    // Power-on reset state with idle inputs.
    #2;
    checks++;
    if ({ov1, cout1, sum1} !== 3'b000 || ov8 !== 1'b0) begin
      failures++;
      $display("FAIL reset_init got ov1/c/s=%b%b%b ov8=%b exp=000/0", ov1, cout1, sum1, ov8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 8'hFF, 8'h01, 1'b1);
    checks++;
    if (ov1 !== 1'b1 || q1.size() == 0 || {cout1, sum1} !== q1.pop_front()) begin
      failures++;
      $display("FAIL reset_pre got ov=%b cs=%b exp ov=1 cs=10", ov1, {cout1, sum1});
    end
    checks++;
    if (ov8 !== 1'b1 || q8.size() == 0 || {cout8, sum8} !== q8.pop_front()) begin
      failures++;
      $display("FAIL reset_pre8 got ov=%b cs=%h", ov8, {cout8, sum8});
    end
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1;
    a8 = 8'hAA; b8 = 8'hFF; iv8 = 1'b1;
    #2 rst_n = 1'b0;
    #1;
`ifdef HALF_ADDER_REG_OUT_EN
    checks++;
    if ({ov1, cout1, sum1} !== 3'b000 || {ov8, cout8, sum8} !== 17'd0) begin
      failures++;
      $display("FAIL reset_async got ov1/c/s=%b%b%b ov8=%b exp all zero", ov1, cout1, sum1, ov8);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({ov1, cout1, sum1} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ignore_valid got=%b%b%b exp=000", ov1, cout1, sum1);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({ov1, cout1, sum1} !== 3'b110) begin
      failures++;
      $display("FAIL reset_first_capture got=%b%b%b exp=110", ov1, cout1, sum1);
    end
`else
    checks++;
    if ({ov1, cout1, sum1} !== 3'b110) begin
      failures++;
      $display("FAIL reset_no_effect got=%b%b%b exp=110", ov1, cout1, sum1);
    end
    rst_n = 1'b1;
`endif
    iv1 = 1'b0;
    iv8 = 1'b0;
  endtask

  task automatic test_sweep;
    for (int i = 0; i < 4; i++) begin
      drive(i[1], i[0], 1'b1, 8'h00, 8'h00, 1'b0);
      checks++;
      if (ov1 !== 1'b1) begin
        failures++;
        $display("FAIL sweep_valid ab=%0d got=%b exp=1", i, ov1);
      end
      checks++;
      if (q1.size() == 0 || {cout1, sum1} !== q1.pop_front()) begin
        failures++;
        $display("FAIL sweep_result ab=%0d got=%b", i, {cout1, sum1});
      end
    end
  endtask

  task automatic test_hold;
    drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    checks++;
    if (ov1 !== 1'b1 || q1.size() == 0 || {cout1, sum1} !== q1.pop_front()) begin
      failures++;
      $display("FAIL hold_load got ov=%b cs=%b exp ov=1 cs=10", ov1, {cout1, sum1});
    end
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
`ifdef HALF_ADDER_REG_OUT_EN
    checks++;
    if ({ov1, cout1, sum1} !== 3'b010) begin
      failures++;
      $display("FAIL hold_keep got=%b%b%b exp=010", ov1, cout1, sum1);
    end
`else
    checks++;
    if ({ov1, cout1, sum1} !== 3'b001) begin
      failures++;
      $display("FAIL hold_comb got=%b%b%b exp=001", ov1, cout1, sum1);
    end
`endif
  endtask

  task automatic test_lanes8;
    drive(1'b0, 1'b0, 1'b0, 8'hF0, 8'hCC, 1'b1);
    checks++;
    if (ov8 !== 1'b1 || sum8 !== 8'h3C || cout8 !== 8'hC0) begin
      failures++;
      $display("FAIL lanes8 got ov=%b sum=%h cout=%h exp ov=1 sum=3c cout=c0", ov8, sum8, cout8);
    end
    if (q8.size() != 0) void'(q8.pop_front());
  endtask

  task automatic test_back_to_back;
    logic       ra, rb;
    logic [7:0] ra8, rb8;
    int         bad;
    bad = 0;
    for (int n = 0; n < 1000; n++) begin
      ra  = 1'($urandom_range(0, 1));
      rb  = 1'($urandom_range(0, 1));
      ra8 = 8'($urandom);
      rb8 = 8'($urandom);
      drive(ra, rb, 1'b1, ra8, rb8, 1'b1);
      checks++;
      if (ov1 !== 1'b1 || ov8 !== 1'b1) begin
        failures++;
        if (bad++ < 10) $display("FAIL stream_valid n=%0d got ov1=%b ov8=%b exp=1/1", n, ov1, ov8);
      end
      checks++;
      if (q1.size() == 0 || {cout1, sum1} !== q1.pop_front()) begin
        failures++;
        if (bad++ < 10) $display("FAIL stream_lane1 n=%0d got=%b", n, {cout1, sum1});
      end
      checks++;
      if (q8.size() == 0 || {cout8, sum8} !== q8.pop_front()) begin
        failures++;
        if (bad++ < 10) $display("FAIL stream_lane8 n=%0d got=%h exp=%h", n, {cout8, sum8}, exp8(ra8, rb8));
      end
    end
    checks++;
    if (q1.size() != 0 || q8.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got q1=%0d q8=%0d exp=0/0", q1.size(), q8.size());
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clk      = 1'b0;
    rst_n    = 1'b0;
    a1 = 1'b0; b1 = 1'b0; iv1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; iv8 = 1'b0;
    test_pkg_model;
    test_reset;
    test_sweep;
    test_hold;
    test_lanes8;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
